// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
//   Centisecond stopwatch counting MM:SS.CC in BCD, advanced by a 100 Hz level
//   (tick_in) sampled in the clkin domain. A three-state FSM (IDLE/RUN/STOP)
//   is driven by one-cycle command pulses. The count saturates at 59:59.99,
//   raising a sticky overflow flag and stopping the watch.
//
//   Optional feature: define STOPWATCH_LAP_EN to enable the lap display hold.
//   A lap pulse in RUN freezes the displayed digits while counting continues;
//   a second lap pulse, a clear into IDLE or reset releases the hold.
//
// Ports
//   clkin      in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   tick_in    in   1  100 Hz square wave, treated as a level
//   start_stop in   1  command pulse: IDLE/STOP -> RUN, RUN -> STOP
//   clear      in   1  command pulse: STOP -> IDLE with count zeroed
//   lap        in   1  command pulse: toggles display hold (lap build only)
//   running    out  1  high while in RUN
//   cs_bcd     out  8  centiseconds, BCD 00-99
//   sec_bcd    out  8  seconds, BCD 00-59
//   min_bcd    out  8  minutes, BCD 00-59
//   overflow   out  1  sticky: count saturated at 59:59.99
// -----------------------------------------------------------------------------
module stopwatch_core (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic [7:0] cs_bcd,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  // Count digit packing, most significant first:
  // {min_tens, min_units, sec_tens, sec_units, cs_tens, cs_units}
  localparam logic [23:0] CNT_MAX = 24'h595999;

  state_t      state_q;
  state_t      state_d;
  logic        t1;
  logic        t2;
  logic        tick_pulse;
  logic        adv;
  logic        at_max;
  logic        clr_go;
  logic [23:0] cnt_q;
  logic [23:0] disp;

  // Ripple-carry BCD increment. Sec and min tens digits wrap at 5, all other
  // digits at 9. Using >= on the limit keeps every digit legal even from an
  // out-of-range value.
  function automatic logic [23:0] bcd_inc(input logic [23:0] c);
    logic [23:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[i*4 +: 4] >= lim) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // ---- Stage: tick edge detect (t1/t2) ----
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      t1 <= 1'b0;
      t2 <= 1'b0;
    end else begin
      t1 <= tick_in;
      t2 <= t1;
    end
  end

  assign tick_pulse = t1 & ~t2;
  assign adv        = tick_pulse && (state_q == RUN);
  assign at_max     = (cnt_q == CNT_MAX);
  assign clr_go     = (state_q == STOP) && clear;

  // ---- Stage: FSM state register ----
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state. Saturation and start_stop both leave RUN for STOP, which is
  // also why clear is irrelevant in RUN. In STOP, clear takes priority.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_stop) state_d = RUN;
      RUN:  if ((adv && at_max) || start_stop) state_d = STOP;
      STOP: begin
        if (clear)           state_d = IDLE;
        else if (start_stop) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    running = (state_q == RUN);
  end

  // ---- Stage: count and overflow registers ----
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else if (clr_go) begin
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else if (adv) begin
      if (at_max) overflow <= 1'b1;
      else        cnt_q    <= bcd_inc(cnt_q);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        hold_q;
  logic [23:0] snap_q;

  // ---- Stage: lap hold and snapshot ----
  // The snapshot takes the pre-edge count, i.e. what the display showed when
  // lap was pressed.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else if (clr_go) begin
      hold_q <= 1'b0;
    end else if (lap && (state_q == RUN)) begin
      hold_q <= ~hold_q;
      if (!hold_q) snap_q <= cnt_q;
    end
  end

  assign disp = hold_q ? snap_q : cnt_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign disp       = cnt_q;
`endif

  assign cs_bcd  = disp[7:0];
  assign sec_bcd = disp[15:8];
  assign min_bcd = disp[23:16];

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       running;
  logic [7:0] cs_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: total elapsed centiseconds plus a symbolic state.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_MAX  = 59*6000 + 59*100 + 99;

  int m_cnt   = 0;
  int m_state = M_IDLE;
  int m_ovf   = 0;
  int m_hold  = 0;
  int m_snap  = 0;

  stopwatch_core dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .tick_in    (tick_in),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .running    (running),
    .cs_bcd     (cs_bcd),
    .sec_bcd    (sec_bcd),
    .min_bcd    (min_bcd),
    .overflow   (overflow)
  );

  always #10 clkin = ~clkin;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic expect_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic check(input string tag);
    int d;
    d = (m_hold != 0) ? m_snap : m_cnt;
    expect_byte({tag, ".cs"},  cs_bcd,  to_bcd(d % 100));
    expect_byte({tag, ".sec"}, sec_bcd, to_bcd((d / 100) % 60));
    expect_byte({tag, ".min"}, min_bcd, to_bcd(d / 6000));
    expect_bit({tag, ".running"},  running,  m_state == M_RUN);
    expect_bit({tag, ".overflow"}, overflow, m_ovf != 0);
  endtask

  task automatic model_tick();
    if (m_state == M_RUN) begin
      if (m_cnt == M_MAX) begin
        m_ovf   = 1;
        m_state = M_STOP;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic model_cmd(input bit ss, input bit clr, input bit lp);
    int pre;
    pre = m_state;
`ifdef STOPWATCH_LAP_EN
    if (lp && pre == M_RUN) begin
      if (m_hold == 0) begin
        m_snap = m_cnt;
        m_hold = 1;
      end else begin
        m_hold = 0;
      end
    end
`endif
    case (pre)
      M_IDLE: if (ss) m_state = M_RUN;
      M_RUN:  if (ss) m_state = M_STOP;
      default: begin
        if (clr) begin
          m_state = M_IDLE;
          m_cnt   = 0;
          m_ovf   = 0;
          m_hold  = 0;
        end else if (ss) begin
          m_state = M_RUN;
        end
      end
    endcase
  endtask

  task automatic model_reset();
    m_cnt = 0; m_state = M_IDLE; m_ovf = 0; m_hold = 0; m_snap = 0;
  endtask

  // One tick_in period: high for hi clocks, low for lo clocks. Ends on a
  // falling clkin edge with the resulting count already settled.
  task automatic tick_edge(input int hi, input int lo);
    @(negedge clkin) tick_in = 1'b1;
    model_tick();
    repeat (hi) @(negedge clkin);
    tick_in = 1'b0;
    repeat (lo) @(negedge clkin);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_edge(1, 1);
  endtask

  task automatic cmd(input bit ss, input bit clr, input bit lp);
    @(negedge clkin);
    start_stop = ss; clear = clr; lap = lp;
    model_cmd(ss, clr, lp);
    @(negedge clkin);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clkin);
    check("reset");
    rst_n = 1'b1;
    @(negedge clkin);
    check("post_reset");

    // Start, then 150 ticks with random high/low times
    cmd(1, 0, 0);
    for (int i = 0; i < 150; i++) tick_edge($urandom_range(1, 3), $urandom_range(1, 3));
    check("t150");
    expect_byte("t150.cs_const", cs_bcd, 8'h50);
    expect_byte("t150.sec_const", sec_bcd, 8'h01);
    expect_bit("t150.run_const", running, 1'b1);

    // Long tick high time gives exactly one increment
    tick_edge(1000, 2);
    check("long_high");
    expect_byte("long_high.cs_const", cs_bcd, 8'h51);

    // Reach 00:12.34 in RUN; start_stop+clear in RUN -> STOP, count held
    ticks(1234 - 151);
    check("at1234");
    cmd(1, 1, 0);
    check("run_ss_clr");
    expect_byte("run_ss_clr.cs_const", cs_bcd, 8'h34);
    expect_byte("run_ss_clr.sec_const", sec_bcd, 8'h12);
    expect_bit("run_ss_clr.run_const", running, 1'b0);
    // start_stop+clear in STOP -> IDLE, zeros
    cmd(1, 1, 0);
    check("stop_ss_clr");
    expect_byte("stop_ss_clr.sec_const", sec_bcd, 8'h00);

    // STOP at zero; tick coincides with the STOP->RUN command
    cmd(1, 0, 0);
    cmd(1, 0, 0);
    check("stop_zero");
    @(negedge clkin) tick_in = 1'b1;
    @(negedge clkin) start_stop = 1'b1;
    model_cmd(1, 0, 0);
    @(negedge clkin);
    start_stop = 1'b0;
    tick_in = 1'b0;
    @(negedge clkin);
    check("coincide");
    expect_byte("coincide.cs_const", cs_bcd, 8'h00);
    expect_bit("coincide.run_const", running, 1'b1);
    tick_edge(1, 1);
    check("coincide_next");
    expect_byte("coincide_next.cs_const", cs_bcd, 8'h01);

    // Preload to 59:59.98 (ticking there is far too long), then saturate
    @(negedge clkin) force dut.cnt_q = 24'h595998;
    @(negedge clkin) release dut.cnt_q;
    m_cnt = M_MAX - 1;
    @(negedge clkin);
    check("preload");
    tick_edge(1, 1);
    tick_edge(1, 1);
    check("saturate");
    expect_byte("saturate.min_const", min_bcd, 8'h59);
    expect_byte("saturate.cs_const", cs_bcd, 8'h99);
    expect_bit("saturate.ovf_const", overflow, 1'b1);
    expect_bit("saturate.run_const", running, 1'b0);
    tick_edge(1, 1);
    check("sat_stop_tick");
    cmd(0, 1, 0);
    check("sat_clear");
    expect_bit("sat_clear.ovf_const", overflow, 1'b0);

    // Lap behaviour
`ifdef STOPWATCH_LAP_EN
    cmd(1, 0, 0);
    ticks(300);
    cmd(0, 0, 1);
    ticks(200);
    check("lap_hold");
    expect_byte("lap_hold.sec_const", sec_bcd, 8'h03);
    expect_byte("lap_hold.cs_const", cs_bcd, 8'h00);
    cmd(0, 0, 1);
    check("lap_release");
    expect_byte("lap_release.sec_const", sec_bcd, 8'h05);
`else
    cmd(1, 0, 0);
    ticks(30);
    cmd(0, 0, 1);
    ticks(20);
    check("lap_ignored");
    expect_byte("lap_ignored.cs_const", cs_bcd, 8'h50);
`endif
    cmd(1, 0, 0);
    cmd(0, 1, 0);
    check("back_idle");

    // Random mix of ticks and commands against the model
    repeat (200) begin
      if ($urandom_range(0, 9) < 6)
        tick_edge($urandom_range(1, 4), $urandom_range(1, 4));
      else
        cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rand");
    end

    // Asynchronous reset mid-count with tick_in high across release
    @(negedge clkin) rst_n = 1'b0;
    model_reset();
    @(negedge clkin) rst_n = 1'b1;
    cmd(1, 0, 0);
    ticks(37);
    check("pre_abort");
    @(negedge clkin) tick_in = 1'b1;
    #3 rst_n = 1'b0;
    model_reset();
    #1 check("async_abort");
    @(negedge clkin);
    @(negedge clkin) rst_n = 1'b1;
    repeat (4) @(negedge clkin);
    tick_in = 1'b0;
    repeat (2) @(negedge clkin);
    check("release_tick_high");
    cmd(1, 0, 0);
    tick_edge(1, 1);
    check("after_abort");
    expect_byte("after_abort.cs_const", cs_bcd, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
